// File: rtl/debug_program_loader_if.sv
// debug_program_loader_if: UART receive byte stream plus fetch-stage debug port.
// The loader drives the debug side as master; the UART/fetch side attaches as slave.
interface debug_program_loader_if #(
   parameter int NB_BITS = 32,
   parameter int NB_ADDR = 10
);
   logic [7:0]         i_rx_data;
   logic               i_rx_valid;
   logic [NB_BITS-1:0] o_data_debug;
   logic [NB_ADDR-1:0] o_addr_debug;
   logic               o_wren_debug;
   logic               o_debug;
   logic               o_step;
   logic               o_load_done;
   logic [NB_ADDR:0]   o_word_count;
   logic               o_error;
   modport master (
      input  i_rx_data, i_rx_valid,
      output o_data_debug, o_addr_debug, o_wren_debug, o_debug, o_step,
             o_load_done, o_word_count, o_error
   );
   modport slave (
      output i_rx_data, i_rx_valid,
      input  o_data_debug, o_addr_debug, o_wren_debug, o_debug, o_step,
             o_load_done, o_word_count, o_error
   );
endinterface

// File: rtl/debug_program_loader.sv
// debug_program_loader: assembles UART bytes into instruction words, writes them to fetch memory, then runs or single-steps.
// Defining LOADER_TIMEOUT_EN adds an inter-byte load timeout that aborts the load and pulses o_error.
module debug_program_loader #(
   parameter int                 NB_BITS   = 32,
   parameter int                 NB_ADDR   = 10,
   parameter logic [NB_BITS-1:0] END_WORD  = {NB_BITS{1'b1}},
   parameter int                 STEP_HOLD = 2
`ifdef LOADER_TIMEOUT_EN
   , parameter int               TIMEOUT_CYCLES = 1_000_000
`endif
) (
   input logic                    i_clk,
   input logic                    i_rst,
   debug_program_loader_if.master bus
);
   localparam int NB_BYTES = NB_BITS / 8;
   localparam int NB_BCNT  = $clog2(NB_BYTES + 1);
   localparam int NB_HOLD  = $clog2(STEP_HOLD + 1);
   localparam logic [7:0] CMD_L = 8'h4C, CMD_R = 8'h52, CMD_S = 8'h53, CMD_N = 8'h4E, CMD_E = 8'h45;

   typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, STEP} state_t;

   state_t             r_state, w_next, w_idle_cmd;
   logic [NB_BITS-1:0] r_word, r_data_debug, w_word;
   logic [NB_ADDR-1:0] r_addr, r_addr_debug;
   logic [NB_ADDR:0]   r_word_count;
   logic [NB_BCNT-1:0] r_bcnt;
   logic [NB_HOLD-1:0] r_hold;
   logic               r_wren, r_load_done, r_step;
   logic               w_rx, w_loading, w_last, w_start, w_timeout;
   logic [7:0]         w_byte;

   assign w_rx      = bus.i_rx_valid;
   assign w_byte    = bus.i_rx_data;
   assign w_word    = NB_BITS'({r_word, w_byte});
   // A WRITE that does not end the load keeps collecting the next word's bytes.
   assign w_loading = r_state == LOAD || (r_state == WRITE && !r_load_done);
   assign w_last    = w_loading && w_rx && r_bcnt == NB_BCNT'(NB_BYTES - 1);
   assign w_start   = (r_state == IDLE || (r_state == WRITE && r_load_done)) && w_next == LOAD;
   assign w_idle_cmd = !w_rx            ? IDLE :
                       w_byte == CMD_L  ? LOAD :
                       w_byte == CMD_R  ? RUN  :
                       w_byte == CMD_S  ? STEP : IDLE;

   always_ff @(posedge i_clk)
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:  w_next = w_idle_cmd;
         LOAD:  w_next = w_timeout ? IDLE : w_last ? WRITE : LOAD;
         WRITE: w_next = r_load_done ? w_idle_cmd : w_last ? WRITE : LOAD;
         RUN:   w_next = (w_rx && w_byte == CMD_S) ? STEP : (w_rx && w_byte == CMD_E) ? IDLE : RUN;
         STEP:  w_next = (w_rx && w_byte == CMD_R) ? RUN : (w_rx && w_byte == CMD_E) ? IDLE : STEP;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_word       <= '0;
         r_data_debug <= '0;
         r_addr       <= '0;
         r_addr_debug <= '0;
         r_word_count <= '0;
         r_bcnt       <= '0;
         r_wren       <= 1'b0;
         r_load_done  <= 1'b0;
      end else begin
         r_wren      <= 1'b0;
         r_load_done <= 1'b0;
         if (w_start) begin
            r_addr       <= '0;
            r_bcnt       <= '0;
            r_word_count <= '0;
         end else if (w_loading && w_rx) begin
            r_word <= w_word;
            r_bcnt <= w_last ? '0 : r_bcnt + 1'b1;
            // Strobe, address and data are registered together so they are stable for the whole write cycle.
            if (w_last && w_word == END_WORD) begin
               r_load_done <= 1'b1;
            end else if (w_last) begin
               r_wren       <= 1'b1;
               r_load_done  <= &r_addr;
               r_data_debug <= w_word;
               r_addr_debug <= r_addr;
               r_addr       <= r_addr + 1'b1;
               r_word_count <= r_word_count + {{NB_ADDR{1'b0}}, !r_word_count[NB_ADDR]};
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_step <= 1'b0;
         r_hold <= '0;
      end else if (w_next != STEP) begin
         r_step <= 1'b0;
      end else if (r_step) begin
         r_step <= r_hold != '0;
         r_hold <= r_hold - (r_hold != '0 ? 1'b1 : 1'b0);
      end else if (r_state == STEP && w_rx && w_byte == CMD_N) begin
         r_step <= 1'b1;
         r_hold <= NB_HOLD'(STEP_HOLD - 1);
      end
   end

`ifdef LOADER_TIMEOUT_EN
   localparam int NB_TMO = $clog2(TIMEOUT_CYCLES + 1);
   logic [NB_TMO-1:0] r_tmo;
   logic              r_error;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tmo   <= '0;
         r_error <= 1'b0;
      end else begin
         r_tmo   <= (!w_loading || w_rx) ? '0 : r_tmo + 1'b1;
         r_error <= w_timeout;
      end
   end
   assign w_timeout   = r_state == LOAD && !w_rx && r_tmo == NB_TMO'(TIMEOUT_CYCLES - 1);
   assign bus.o_error = r_error;
`else
   assign w_timeout   = 1'b0;
   assign bus.o_error = 1'b0;
`endif

   assign bus.o_data_debug = r_data_debug;
   assign bus.o_addr_debug = r_addr_debug;
   assign bus.o_wren_debug = r_wren;
   assign bus.o_debug      = r_state != RUN;
   assign bus.o_step       = r_step;
   assign bus.o_load_done  = r_load_done;
   assign bus.o_word_count = r_word_count;
endmodule

// File: tb/tb_debug_program_loader.sv
// tb_debug_program_loader: scoreboard bench; a byte-level behavioural model predicts writes, load ends, steps and errors.
// Build with LOADER_TIMEOUT_EN defined to also cover the load timeout.
module tb_debug_program_loader;
   localparam int NB_ADDR = 2;
   localparam int DEPTH   = 1 << NB_ADDR;
   localparam int HOLD    = 2;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] cnt;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   debug_program_loader_if #(.NB_BITS(32), .NB_ADDR(NB_ADDR)) bus ();

   debug_program_loader #(
      .NB_BITS(32), .NB_ADDR(NB_ADDR), .STEP_HOLD(HOLD)
`ifdef LOADER_TIMEOUT_EN
      , .TIMEOUT_CYCLES(50)
`endif
   ) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   ev_t         q[$];
   int          errs = 0, checks = 0, t = 0;
   int          mode, nb, maddr, mcount, last_step;
   logic [31:0] mbuf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int k, input int a, input logic [31:0] d, input int c);
      ev_t e;
      e.kind = k; e.addr = 32'(a); e.data = d; e.cnt = 32'(c);
      q.push_back(e);
   endtask

   task automatic mreset();
      mode = 0; nb = 0; maddr = 0; mcount = 0; last_step = -100; mbuf = '0;
   endtask

   // kinds: 0 write, 1 write ending the load, 2 end marker, 3 step pulse, 4 timeout error
   task automatic model(input logic [7:0] b, input int e);
      case (mode)
         0: if (b == 8'h4C) begin mode = 1; nb = 0; maddr = 0; mcount = 0; end
            else if (b == 8'h52) mode = 2;
            else if (b == 8'h53) mode = 3;
         1: begin
            mbuf = {mbuf[23:0], b};
            nb++;
            if (nb == 4) begin
               nb = 0;
               if (mbuf == 32'hFFFF_FFFF) begin
                  push(2, 0, 0, mcount);
                  mode = 0;
               end else begin
                  if (mcount < DEPTH) mcount++;
                  push(maddr == DEPTH - 1 ? 1 : 0, maddr, mbuf, mcount);
                  if (maddr == DEPTH - 1) mode = 0;
                  maddr = (maddr + 1) % DEPTH;
               end
            end
         end
         2: if (b == 8'h53) mode = 3; else if (b == 8'h45) mode = 0;
         3: if (b == 8'h4E) begin
               if (e - last_step > HOLD) begin push(3, 0, 0, HOLD); last_step = e; end
            end else if (b == 8'h52) mode = 2;
            else if (b == 8'h45) mode = 0;
         default: mode = 0;
      endcase
   endtask

   task automatic tick();
      @(negedge clk);
      t++;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      model(b, t + 1);
      bus.i_rx_data  = b;
      bus.i_rx_valid = 1'b1;
      tick();
      bus.i_rx_valid = 1'b0;
      chk("o_debug", 32'(bus.o_debug), 32'(mode != 2));
      repeat (gap) tick();
   endtask

   task automatic send_word(input logic [31:0] w, input bit rnd);
      for (int i = 3; i >= 0; i--) send(w[8*i +: 8], i == 0 ? 3 : (rnd ? int'($urandom_range(0, 2)) : 0));
   endtask

   task automatic chk_reset_values();
      chk("rst_data", bus.o_data_debug, 0);
      chk("rst_addr", 32'(bus.o_addr_debug), 0);
      chk("rst_wren", 32'(bus.o_wren_debug), 0);
      chk("rst_debug", 32'(bus.o_debug), 1);
      chk("rst_step", 32'(bus.o_step), 0);
      chk("rst_done", 32'(bus.o_load_done), 0);
      chk("rst_count", 32'(bus.o_word_count), 0);
      chk("rst_error", 32'(bus.o_error), 0);
   endtask

   int  slen = 0;
   int  ok;
   ev_t me;
   always @(negedge clk) begin
      if (rst) begin
         slen = 0;
      end else begin
         if (bus.o_wren_debug || bus.o_load_done || bus.o_error) begin
            ok = bus.o_error ? 4 : (bus.o_wren_debug && bus.o_load_done) ? 1 : bus.o_wren_debug ? 0 : 2;
            if (q.size() == 0) begin
               checks++; errs++;
               $display("FAIL unexpected_event: got kind %0d expected none", ok);
            end else begin
               me = q.pop_front();
               chk("event_kind", 32'(ok), 32'(me.kind));
               if (ok <= 1) begin
                  chk("write_addr", 32'(bus.o_addr_debug), me.addr);
                  chk("write_data", bus.o_data_debug, me.data);
               end
               if (ok <= 2) chk("word_count", 32'(bus.o_word_count), me.cnt);
            end
         end
         if (bus.o_step) begin
            slen++;
         end else if (slen > 0) begin
            if (q.size() == 0) begin
               checks++; errs++;
               $display("FAIL unexpected_step: got length %0d expected none", slen);
            end else begin
               me = q.pop_front();
               chk("step_kind", 3, 32'(me.kind));
               chk("step_len", 32'(slen), me.cnt);
            end
            slen = 0;
         end
      end
   end

   logic [7:0] cmds[6];
   initial begin
      cmds = '{8'h4C, 8'h52, 8'h53, 8'h4E, 8'h45, 8'h00};
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'h00;
      mreset();
      repeat (3) tick();
      chk_reset_values();
      rst = 1'b0;
      tick();
      // normal load ending with the end marker
      send(8'h4C, 1);
      send_word(32'h0000_0020, 1'b0);
      send_word(32'h8C01_0004, 1'b0);
      send_word(32'hFFFF_FFFF, 1'b0);
      repeat (3) tick();
      chk("load_count", 32'(bus.o_word_count), 2);
      chk("data_held", bus.o_data_debug, 32'h8C01_0004);
      // full memory: fifth word's first byte is 'R'
      send(8'h4C, 0);
      send_word(32'h1111_1111, 1'b0);
      send_word(32'h2222_2222, 1'b0);
      send_word(32'h3333_3333, 1'b0);
      send_word(32'h4444_4444, 1'b0);
      send_word(32'h520A_0B0C, 1'b0);
      chk("full_count", 32'(bus.o_word_count), DEPTH);
      send(8'h45, 3);
      // stepping
      send(8'h53, 10);
      send(8'h4E, 10);
      send(8'h4E, 10);
      send(8'h4E, 0);
      send(8'h4E, 10);
      // run mode ignores 'N'
      send(8'h52, 3);
      send(8'h4E, 5);
      send(8'h45, 3);
`ifdef LOADER_TIMEOUT_EN
      send(8'h4C, 1);
      send(8'h12, 0);
      send(8'h34, 0);
      push(4, 0, 0, 0);
      mode = 0;
      repeat (60) tick();
      chk("tmo_debug", 32'(bus.o_debug), 1);
`endif
      // reset in the middle of a word
      send(8'h4C, 1);
      send(8'hAB, 0);
      send(8'hCD, 0);
      rst = 1'b1;
      mreset();
      repeat (3) tick();
      chk_reset_values();
      rst = 1'b0;
      tick();
      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         if (mode == 1) send_word(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom), 1'b1);
         else send(cmds[$urandom_range(0, 5)] ^ (($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00),
                   int'($urandom_range(3, 5)));
      end
      repeat (10) tick();
      chk("queue_empty", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
